// File: rtl/conv_pkg.sv
// Phase codes shared with the memory controller, plus a counter-width helper.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        PROC = 2'b01,
        OUT  = 2'b10,
        IDLE = 2'b11
    } phase_e;

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/conv_modcnt.sv
// Wrap-around counter 0..MAX with enable, synchronous clear and terminal-count flag.
module conv_modcnt
    import conv_pkg::*;
#(
    parameter int unsigned MAX   = 7,
    parameter int unsigned WIDTH = cnt_width(MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc_c
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign o_tc_c = (cnt_q == WIDTH'(MAX));
    assign o_cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tc_c ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_seq.sv
// Line-buffer convolution sequencer: LOAD column blocks, PROC, stream OUT, per pass.
// Define CONV_SEQ_ERR_EN to build the sticky protocol-error detector behind o_err.
module conv_seq
    import conv_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned IMG_WIDTH  = 8,
    parameter int unsigned IMG_HEIGHT = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_load_valid,
    input  logic                         i_out_ready,
    output logic                         o_sop,
    output logic                         o_eop,
    output logic                         o_chblk,
    output logic [$clog2(IMG_WIDTH)-1:0] o_addr,
    output logic                         o_out_valid,
    output logic                         o_frame_done,
    output logic                         o_err
);

    localparam int unsigned AW        = $clog2(IMG_WIDTH);
    localparam int unsigned PASSES    = IMG_HEIGHT - N;
    localparam int unsigned PW        = cnt_width(PASSES);
    localparam int unsigned BW        = cnt_width(N + 1);
    localparam int unsigned LAST_WORD = IMG_WIDTH - N - 1;

    phase_e        state_q, state_d;
    logic          chblk_q, chblk_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;

    logic [AW-1:0] addr_cnt;
    logic          addr_en, addr_clr, addr_tc_c;
    logic [PW-1:0] pass_cnt;
    logic          pass_en, pass_clr, pass_tc_c;
    logic [BW-1:0] blk_cnt;
    logic          blk_en, blk_clr, blk_tc_c;
    logic          last_blk_c;

    conv_modcnt #(.MAX(IMG_WIDTH - 1), .WIDTH(AW)) u_addr_cnt (
        .clk(clk), .rst(rst), .i_en(addr_en), .i_clr(addr_clr),
        .o_cnt(addr_cnt), .o_tc_c(addr_tc_c)
    );

    conv_modcnt #(.MAX(PASSES), .WIDTH(PW)) u_pass_cnt (
        .clk(clk), .rst(rst), .i_en(pass_en), .i_clr(pass_clr),
        .o_cnt(pass_cnt), .o_tc_c(pass_tc_c)
    );

    conv_modcnt #(.MAX(N + 1), .WIDTH(BW)) u_blk_cnt (
        .clk(clk), .rst(rst), .i_en(blk_en), .i_clr(blk_clr),
        .o_cnt(blk_cnt), .o_tc_c(blk_tc_c)
    );

    // The first pass fills all N+1 line-buffer banks; later passes refill one.
    assign last_blk_c = (pass_cnt == '0) ? blk_tc_c : (blk_cnt == BW'(1));

    always_comb begin
        state_d      = state_q;
        chblk_d      = 1'b0;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        addr_en      = 1'b0;
        addr_clr     = 1'b0;
        pass_en      = 1'b0;
        pass_clr     = 1'b0;
        blk_en       = 1'b0;
        blk_clr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                addr_clr = 1'b1;
                pass_clr = 1'b1;
                blk_clr  = 1'b1;
                if (i_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Load words arriving during the block-done pulse are dropped.
                if (chblk_q) begin
                    if (last_blk_c) begin
                        state_d = PROC;
                        blk_clr = 1'b1;
                    end
                end else if (i_load_valid) begin
                    addr_en = 1'b1;
                    if (addr_tc_c) begin
                        chblk_d = 1'b1;
                        blk_en  = 1'b1;
                    end
                end
            end
            PROC: begin
                if (addr_cnt == AW'(LAST_WORD)) begin
                    addr_clr    = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    addr_en = 1'b1;
                end
            end
            OUT: begin
                // All words of the pass are sent; valid stays low in the pulse cycle.
                if (chblk_q) begin
                    if (pass_tc_c) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    out_valid_d = 1'b1;
                    if (out_valid_q && i_out_ready) begin
                        if (addr_cnt == AW'(LAST_WORD)) begin
                            addr_clr    = 1'b1;
                            pass_en     = 1'b1;
                            chblk_d     = 1'b1;
                            out_valid_d = 1'b0;
                        end else begin
                            addr_en = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            chblk_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            chblk_q      <= chblk_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_sop        = state_q[0];
    assign o_eop        = state_q[1];
    assign o_addr       = addr_cnt;
    assign o_chblk      = chblk_q;
    assign o_out_valid  = out_valid_q;
    assign o_frame_done = frame_done_q;

`ifdef CONV_SEQ_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (i_load_valid && (state_q != LOAD))
                      | (i_start && (state_q != IDLE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_seq.sv
// Directed self-checking bench for conv_seq at N=2, IMG_WIDTH=8, IMG_HEIGHT=5.
module tb_conv_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic       i_load_valid;
    logic       i_out_ready;
    logic       o_sop, o_eop, o_chblk, o_out_valid, o_frame_done, o_err;
    logic [2:0] o_addr;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CONV_SEQ_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    conv_seq #(.N(2), .IMG_WIDTH(8), .IMG_HEIGHT(5)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_load_valid(i_load_valid),
        .i_out_ready(i_out_ready), .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk),
        .o_addr(o_addr), .o_out_valid(o_out_valid), .o_frame_done(o_frame_done),
        .o_err(o_err)
    );

    assign phase = {o_eop, o_sop};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame and feed the first three blocks until the OUT phase (ready held low).
    task automatic run_to_out();
        int pulses = 0;
        i_start = 1'b1;
        tick();
        i_start      = 1'b0;
        i_load_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (o_chblk) pulses++;
            if (pulses == 3) i_load_valid = 1'b0;
            if (phase == 2'b10) break;
        end
        i_load_valid = 1'b0;
        n_checks++;
        if (phase !== 2'b10) begin
            n_fail++;
            $display("FAIL run_to_out: phase %b, required 10", phase);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_load_valid = 1'b0; i_out_ready = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (phase !== 2'b11) begin n_fail++; $display("FAIL reset_phase: got %b, required 11", phase); end
        n_checks++;
        if (o_addr !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", o_addr); end
        n_checks++;
        if ({o_chblk, o_out_valid, o_frame_done, o_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000", {o_chblk, o_out_valid, o_frame_done, o_err});
        end
        rst = 1'b0;
        tick();
        run_to_out();
        // Asynchronous reset mid-OUT, checked before the next clock edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (phase !== 2'b11) begin n_fail++; $display("FAIL midout_rst_phase: got %b, required 11", phase); end
        n_checks++;
        if (o_addr !== 3'd0) begin n_fail++; $display("FAIL midout_rst_addr: got %0d, required 0", o_addr); end
        n_checks++;
        if ({o_chblk, o_out_valid, o_frame_done, o_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midout_rst_flags: got %b, required 0000", {o_chblk, o_out_valid, o_frame_done, o_err});
        end
        i_start = 1'b1;
        tick();
        n_checks++;
        if (phase !== 2'b11) begin n_fail++; $display("FAIL rst_over_start: phase %b, required 11", phase); end
        rst = 1'b0; i_start = 1'b0;
        tick();
        n_checks++;
        if (phase !== 2'b11) begin n_fail++; $display("FAIL idle_hold: phase %b, required 11", phase); end
    endtask

    task automatic test_first_load();
        int pulses = 0;
        int first_proc = -1;
        int pulse_at [3] = '{-1, -1, -1};
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if (phase !== 2'b00 || o_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL load_entry: phase %b addr %0d, required 00 / 0", phase, o_addr);
        end
        i_load_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (o_chblk) begin
                if (pulses < 3) pulse_at[pulses] = i;
                pulses++;
                if (pulses == 3) i_load_valid = 1'b0;
            end
            if (i == 9) begin
                n_checks++;
                if (o_addr !== 3'd0) begin n_fail++; $display("FAIL pulse_ignore: addr %0d, required 0", o_addr); end
            end
            if (phase == 2'b01) begin
                first_proc = i;
                break;
            end
        end
        i_load_valid = 1'b0;
        n_checks++;
        if (pulses != 3) begin n_fail++; $display("FAIL load_pulses: got %0d, required 3", pulses); end
        n_checks++;
        if (pulse_at[0] != 8 || pulse_at[1] != 17 || pulse_at[2] != 26) begin
            n_fail++;
            $display("FAIL pulse_spacing: got %0d,%0d,%0d, required 8,17,26", pulse_at[0], pulse_at[1], pulse_at[2]);
        end
        n_checks++;
        if (first_proc != 27) begin n_fail++; $display("FAIL proc_entry: cycle %0d, required 27", first_proc); end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (phase !== 2'b01 || o_addr !== 3'(k)) begin
                n_fail++;
                $display("FAIL proc_cycle%0d: phase %b addr %0d, required 01 / %0d", k, phase, o_addr, k);
            end
            tick();
        end
        n_checks++;
        if (phase !== 2'b10 || o_addr !== 3'd0 || o_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_entry: phase %b addr %0d valid %b, required 10 / 0 / 1", phase, o_addr, o_out_valid);
        end
    endtask

    task automatic test_out_backpressure();
        int         accepted = 0;
        logic [2:0] exp_addr = 3'd0;
        for (int k = 0; k < 30 && accepted < 6; k++) begin
            i_out_ready = (k % 2 == 0);
            tick();
            if (i_out_ready) begin
                accepted++;
                exp_addr = (accepted == 6) ? 3'd0 : exp_addr + 3'd1;
            end
            n_checks++;
            if (o_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL bp_addr k=%0d: got %0d, required %0d", k, o_addr, exp_addr);
            end
            n_checks++;
            if (accepted < 6) begin
                if (o_out_valid !== 1'b1 || o_chblk !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_valid k=%0d: valid %b chblk %b, required 1 / 0", k, o_out_valid, o_chblk);
                end
            end else if (o_chblk !== 1'b1 || phase !== 2'b10) begin
                n_fail++;
                $display("FAIL bp_chblk: chblk %b phase %b, required 1 / 10", o_chblk, phase);
            end
        end
        i_out_ready = 1'b0;
        n_checks++;
        if (accepted != 6) begin n_fail++; $display("FAIL bp_accepted: got %0d, required 6", accepted); end
        tick();
        n_checks++;
        if (phase !== 2'b00 || o_addr !== 3'd0 || o_chblk !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_load: phase %b addr %0d chblk %b, required 00 / 0 / 0", phase, o_addr, o_chblk);
        end
    endtask

    task automatic test_stray();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if (phase !== 2'b00 || o_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL stray_start: phase %b addr %0d, required 00 / 0", phase, o_addr);
        end
        n_checks++;
        if (o_err !== EXP_ERR) begin n_fail++; $display("FAIL stray_start_err: got %b, required %b", o_err, EXP_ERR); end
        i_load_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (i < 8 && o_addr !== 3'(i)) begin
                n_fail++;
                $display("FAIL pass1_addr%0d: got %0d, required %0d", i, o_addr, i);
            end else if (i == 8 && o_chblk !== 1'b1) begin
                n_fail++;
                $display("FAIL pass1_chblk: got %b, required 1", o_chblk);
            end
        end
        i_load_valid = 1'b0;
        tick();
        n_checks++;
        if (phase !== 2'b01 || o_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL pass1_proc: phase %b addr %0d, required 01 / 0", phase, o_addr);
        end
        i_load_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (phase !== 2'b01 || o_addr !== 3'(k)) begin
                n_fail++;
                $display("FAIL stray_proc%0d: phase %b addr %0d, required 01 / %0d", k, phase, o_addr, k);
            end
        end
        tick();
        i_load_valid = 1'b0;
        n_checks++;
        if (phase !== 2'b10 || o_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL stray_out: phase %b addr %0d, required 10 / 0", phase, o_addr);
        end
        n_checks++;
        if (o_err !== EXP_ERR) begin n_fail++; $display("FAIL stray_err: got %b, required %b", o_err, EXP_ERR); end
    endtask

    task automatic test_full_frame();
        int         load_cnt = 0;
        int         procs    = 0;
        int         chblks   = 0;
        int         fd       = 0;
        logic [1:0] prev;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        i_out_ready = 1'b1;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            i_load_valid = (phase == 2'b00) && !o_chblk;
            if (i_load_valid) load_cnt++;
            prev = phase;
            tick();
            if (o_chblk) chblks++;
            if (phase == 2'b01 && prev == 2'b00) procs++;
            if (o_frame_done) begin
                fd++;
                break;
            end
        end
        i_load_valid = 1'b0;
        n_checks++;
        if (phase !== 2'b11) begin n_fail++; $display("FAIL frame_end_phase: got %b, required 11", phase); end
        repeat (3) begin
            tick();
            if (o_frame_done) fd++;
        end
        n_checks++;
        if (fd != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d, required 1", fd); end
        n_checks++;
        if (load_cnt != 40) begin n_fail++; $display("FAIL frame_load_words: got %0d, required 40", load_cnt); end
        n_checks++;
        if (procs != 3) begin n_fail++; $display("FAIL frame_passes: got %0d, required 3", procs); end
        n_checks++;
        if (chblks != 8) begin n_fail++; $display("FAIL frame_chblk: got %0d, required 8", chblks); end
        n_checks++;
        if (phase !== 2'b11 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_idle: phase %b err %b, required 11 / 0", phase, o_err);
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_out_backpressure();
        test_stray();
        test_full_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
